izh_param_loader: RTL
=====================

Name: izh_param_loader

Overview:
- Upstream front-end for the Izhikevich neuron core.
- Receives a byte stream over a valid/ready interface and decodes two frame types: parameter frames (a, b, c, d plus XOR checksum) and stimulus frames.
- Commits parameters atomically to the live registers that drive the neuron's param_a..param_d/params_ready inputs, and holds the stimulus byte.
- Generates the neuron's integration-step enable pulse from a fixed clock divider.

Parameters:
- HDR_PARAM, 8'hA5, header byte opening a parameter frame.
- HDR_STIM, 8'h5A, header byte opening a stimulus frame.
- STEP_DIV, 4, clocks per enable pulse (≥1; 1 = enable held high).
- TIMEOUT, 255, max idle cycles between bytes inside a frame before abort.
- A_RST / B_RST / C_RST / D_RST, 2 / 51 / 133 / 8, live parameter reset values.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader can accept byte
- run  in  1  allow enable generation
- param_a, param_b, param_c, param_d  out  8 each  live parameters
- params_ready  out  1  at least one good parameter frame committed
- stimulus_out  out  8  live stimulus value
- enable_out  out  1  one-cycle integration-step pulse
- frame_err  out  1  one-cycle pulse on checksum fail or timeout

Behaviour:
- Reset values:
  - param_a..d = A_RST..D_RST
  - params_ready = 0, stimulus_out = 0, enable_out = 0, frame_err = 0, rx_ready = 1
  - FSM = IDLE, staging registers = 0, counters = 0
- Reset mid-frame discards the frame; live values return to reset values.
- Byte acceptance: a byte is accepted on a rising edge with rx_valid && rx_ready. rx_data is ignored otherwise.
- FSM states: IDLE, PA, PB, PC, PD, PCHK, COMMIT, SVAL.
  - IDLE: HDR_PARAM → PA; HDR_STIM → SVAL; any other byte is silently dropped (no error).
  - PA → PB → PC → PD: each accepted byte is stored in staging register a/b/c/d.
  - PD → PCHK on the 4th byte.
  - PCHK, accepted byte compared with HDR_PARAM ^ a ^ b ^ c ^ d over staging values:
    - match → COMMIT
    - mismatch → IDLE, frame_err=1 for the next cycle, live registers unchanged
  - COMMIT, single cycle:
    - rx_ready = 0
    - all four live params load from staging at the edge ending COMMIT
    - params_ready set at that same edge and stays 1 until reset
    - → IDLE
  - SVAL: accepted byte → stimulus_out at the same edge; → IDLE. No checksum on stimulus frames.
- Latency:
  - Checksum accepted at edge N → new params visible from edge N+1 (cycle N+2).
  - Stimulus byte accepted at edge N → visible from cycle N+1.
- Atomicity: all four params change on one edge. The neuron never sees a mix of old and new values.
- rx_ready = 0 only in COMMIT; 1 in every other state.
- Timeout:
  - In PA..PCHK/SVAL, an idle counter increments each cycle with no accepted byte and clears on acceptance.
  - When the counter reaches TIMEOUT: → IDLE, frame_err pulse, staging discarded, live values unchanged.
  - The counter is held at 0 in IDLE.
- A byte equal to a header value received mid-frame is treated as data, not a restart.
- Enable divider:
  - The step counter runs only while run && params_ready; otherwise counter = 0 and enable_out = 0 (registered).
  - Counts 0..STEP_DIV-1; enable_out = 1 for exactly the cycle after the counter equals STEP_DIV-1, then wraps to 0.
  - First pulse appears STEP_DIV cycles after the first cycle in which run && params_ready is sampled high.
  - STEP_DIV=1 → enable_out continuously high from one cycle after the gate rises.
  - Deasserting run zeroes the counter; the next run restarts the full STEP_DIV interval.
- A commit coinciding with an enable pulse is legal. The pulse is unaffected; the neuron samples either the full old set or the full new set.
- frame_err is never asserted concurrently with a commit.
- Arithmetic is 8-bit XOR for the checksum. The idle counter is $clog2(TIMEOUT+1) bits wide and saturates at TIMEOUT.

Test Plan:
- Reset, then idle 10 cycles:
  - param_a..d = 2/51/133/8, params_ready=0, enable_out stays 0 even with run=1.
- Send A5,02,33,85,08,19 back-to-back with rx_valid=1:
  - rx_ready=0 for exactly 1 cycle after the 0x19 byte
  - params = 02/33/85/08 two cycles after the 0x19 edge
  - params_ready=1, frame_err never asserted
- Same frame with checksum 0x18:
  - frame_err pulses once
  - params and params_ready unchanged
  - the next valid frame commits normally
- Send 5A,7F:
  - stimulus_out=0x7F one cycle after the 0x7F edge; params untouched
- Stray bytes 00,FF before a frame: no error, and the frame still commits.
- Timeout: send A5,02 then hold rx_valid=0 for 255 cycles:
  - frame_err pulse, FSM returns to IDLE
  - the following 33,85,08,19 are dropped as non-headers
- Enable divider, with params_ready=1 and STEP_DIV=4:
  - raise run → pulses every 4th cycle
  - drop run for 2 cycles, then raise → first pulse exactly 4 cycles after re-gate
  - a commit during a run keeps pulse spacing intact

Source files
------------

// File: rtl/izh_param_loader.sv
// Byte-stream front-end for the Izhikevich core: decodes parameter/stimulus frames,
// commits parameters atomically and generates the integration-step enable pulse.
module izh_param_loader #(
  parameter logic [7:0] HDR_PARAM = 8'hA5,
  parameter logic [7:0] HDR_STIM  = 8'h5A,
  parameter int         STEP_DIV  = 4,
  parameter int         TIMEOUT   = 255,
  parameter logic [7:0] A_RST     = 8'd2,
  parameter logic [7:0] B_RST     = 8'd51,
  parameter logic [7:0] C_RST     = 8'd133,
  parameter logic [7:0] D_RST     = 8'd8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  input  logic       run,
  output logic [7:0] param_a,
  output logic [7:0] param_b,
  output logic [7:0] param_c,
  output logic [7:0] param_d,
  output logic       params_ready,
  output logic [7:0] stimulus_out,
  output logic       enable_out,
  output logic       frame_err
);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  typedef enum logic [2:0] {S_IDLE, S_PA, S_PB, S_PC, S_PD, S_PCHK, S_COMMIT, S_SVAL} state_t;

  state_t          state_q, state_d;
  logic [7:0]      stg_a_q, stg_b_q, stg_c_q, stg_d_q;
  logic [7:0]      stg_a_d, stg_b_d, stg_c_d, stg_d_d;
  logic [7:0]      live_a_q, live_b_q, live_c_q, live_d_q;
  logic [7:0]      live_a_d, live_b_d, live_c_d, live_d_d;
  logic            rdy_q, rdy_d, err_q, err_d, en_q, en_d;
  logic [7:0]      stim_q, stim_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            acc, gate;
  logic [7:0]      chk_val;

  assign rx_ready = (state_q != S_COMMIT);
  assign acc      = rx_valid && rx_ready;
  assign chk_val  = HDR_PARAM ^ stg_a_q ^ stg_b_q ^ stg_c_q ^ stg_d_q;
  assign gate     = run && rdy_q;

  always_comb begin
    state_d  = state_q;
    stg_a_d  = stg_a_q;
    stg_b_d  = stg_b_q;
    stg_c_d  = stg_c_q;
    stg_d_d  = stg_d_q;
    live_a_d = live_a_q;
    live_b_d = live_b_q;
    live_c_d = live_c_q;
    live_d_d = live_d_q;
    rdy_d    = rdy_q;
    stim_d   = stim_q;
    err_d    = 1'b0;
    idle_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (acc && rx_data == HDR_PARAM)     state_d = S_PA;
        else if (acc && rx_data == HDR_STIM) state_d = S_SVAL;
      end
      S_COMMIT: begin
        live_a_d = stg_a_q;
        live_b_d = stg_b_q;
        live_c_d = stg_c_q;
        live_d_d = stg_d_q;
        rdy_d    = 1'b1;
        stg_a_d  = '0;
        stg_b_d  = '0;
        stg_c_d  = '0;
        stg_d_d  = '0;
        state_d  = S_IDLE;
      end
      default: begin
        // An expired idle counter wins over a byte arriving the same cycle.
        if (idle_q == IW'(TIMEOUT)) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          stg_a_d = '0;
          stg_b_d = '0;
          stg_c_d = '0;
          stg_d_d = '0;
        end else if (acc) begin
          case (state_q)
            S_PA: begin stg_a_d = rx_data; state_d = S_PB;   end
            S_PB: begin stg_b_d = rx_data; state_d = S_PC;   end
            S_PC: begin stg_c_d = rx_data; state_d = S_PD;   end
            S_PD: begin stg_d_d = rx_data; state_d = S_PCHK; end
            S_PCHK: begin
              if (rx_data == chk_val) begin
                state_d = S_COMMIT;
              end else begin
                state_d = S_IDLE;
                err_d   = 1'b1;
                stg_a_d = '0;
                stg_b_d = '0;
                stg_c_d = '0;
                stg_d_d = '0;
              end
            end
            default: begin stim_d = rx_data; state_d = S_IDLE; end
          endcase
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
    endcase
  end

  // Step divider restarts from zero whenever the gate drops.
  always_comb begin
    cnt_d = '0;
    en_d  = 1'b0;
    if (gate) begin
      en_d  = (cnt_q == CW'(STEP_DIV - 1));
      cnt_d = en_d ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      stg_a_q  <= '0;
      stg_b_q  <= '0;
      stg_c_q  <= '0;
      stg_d_q  <= '0;
      live_a_q <= A_RST;
      live_b_q <= B_RST;
      live_c_q <= C_RST;
      live_d_q <= D_RST;
      rdy_q    <= 1'b0;
      stim_q   <= '0;
      err_q    <= 1'b0;
      idle_q   <= '0;
      cnt_q    <= '0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      stg_a_q  <= stg_a_d;
      stg_b_q  <= stg_b_d;
      stg_c_q  <= stg_c_d;
      stg_d_q  <= stg_d_d;
      live_a_q <= live_a_d;
      live_b_q <= live_b_d;
      live_c_q <= live_c_d;
      live_d_q <= live_d_d;
      rdy_q    <= rdy_d;
      stim_q   <= stim_d;
      err_q    <= err_d;
      idle_q   <= idle_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
    end
  end

  assign param_a      = live_a_q;
  assign param_b      = live_b_q;
  assign param_c      = live_c_q;
  assign param_d      = live_d_q;
  assign params_ready = rdy_q;
  assign stimulus_out = stim_q;
  assign enable_out   = en_q;
  assign frame_err    = err_q;
endmodule
